// File: rtl/regfile_write_arbiter_if.sv
// Writeback-source and register-file write-port bundle for regfile_write_arbiter.
// master = upstream writeback stage / register file side, slave = the arbiter.
interface regfile_write_arbiter_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic                   a_valid;
  logic                   a_ready;
  logic [ADDR_W-1:0]      a_addr;
  logic [DATA_W-1:0]      a_data;
  logic                   b_valid;
  logic                   b_ready;
  logic [ADDR_W-1:0]      b_addr;
  logic [DATA_W-1:0]      b_data;
  logic                   regWrite;
  logic [ADDR_W-1:0]      regWaddr;
  logic [DATA_W-1:0]      data;
  logic [2**ADDR_W-1:0]   pending;

  modport master (
    output a_valid, a_addr, a_data, b_valid, b_addr, b_data,
    input  a_ready, b_ready, regWrite, regWaddr, data, pending
  );

  modport slave (
    input  a_valid, a_addr, a_data, b_valid, b_addr, b_data,
    output a_ready, b_ready, regWrite, regWaddr, data, pending
  );
endinterface

// File: rtl/regfile_write_arbiter.sv
// Two 2-deep writeback queues (A = ALU, B = load) sharing the register-file write port.
// REGWRITE_RR_ARB_EN defined: round-robin grant; undefined: A has fixed priority.
//
// Round-robin pointer (only with REGWRITE_RR_ARB_EN):
//   state  | meaning
//   PRIO_A | A wins when both heads are valid (reset value, and after a B grant)
//   PRIO_B | B wins when both heads are valid (after an A grant)
module regfile_write_arbiter #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic                   clk,
  input  logic                   rst_n,
  regfile_write_arbiter_if.slave wb
);

  localparam int ENTRY_W = ADDR_W + DATA_W;
  localparam int NREG    = 2**ADDR_W;

  logic [ENTRY_W-1:0] mem_q [2][2];
  logic [1:0]         cnt_q    [2];
  logic [1:0]         cnt_d    [2];
  logic               rd_ptr_q [2];
  logic               rd_ptr_d [2];
  logic               wr_ptr_q [2];
  logic               wr_ptr_d [2];

  logic [ENTRY_W-1:0] in_entry [2];
  logic [ENTRY_W-1:0] head     [2];
  logic               ready    [2];
  logic               push     [2];
  logic               pop      [2];
  logic               not_empty[2];

  logic               grant_a;
  logic               grant_b;
  logic [ENTRY_W-1:0] win_entry;

  logic               we_q, we_d;
  logic [ADDR_W-1:0]  waddr_q, waddr_d;
  logic [DATA_W-1:0]  data_q, data_d;
  logic [NREG-1:0]    pend;

  // Ready comes from the registered count only, so a same-cycle pop never opens a full queue.
  always_comb begin
    in_entry[0] = {wb.a_addr, wb.a_data};
    in_entry[1] = {wb.b_addr, wb.b_data};
    for (int s = 0; s < 2; s++) begin
      ready[s]     = (cnt_q[s] != 2'd2);
      not_empty[s] = (cnt_q[s] != 2'd0);
      head[s]      = mem_q[s][rd_ptr_q[s]];
    end
    push[0] = wb.a_valid & ready[0];
    push[1] = wb.b_valid & ready[1];
    pop[0]  = grant_a;
    pop[1]  = grant_b;
    for (int s = 0; s < 2; s++) begin
      cnt_d[s]    = cnt_q[s] + 2'(push[s]) - 2'(pop[s]);
      rd_ptr_d[s] = rd_ptr_q[s] ^ pop[s];
      wr_ptr_d[s] = wr_ptr_q[s] ^ push[s];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < 2; s++) begin
        cnt_q[s]    <= 2'd0;
        rd_ptr_q[s] <= 1'b0;
        wr_ptr_q[s] <= 1'b0;
      end
    end else begin
      for (int s = 0; s < 2; s++) begin
        cnt_q[s]    <= cnt_d[s];
        rd_ptr_q[s] <= rd_ptr_d[s];
        wr_ptr_q[s] <= wr_ptr_d[s];
      end
    end
  end

  // Storage needs no reset: entries are only observed while the count covers them.
  always_ff @(posedge clk) begin
    for (int s = 0; s < 2; s++) begin
      if (push[s]) begin
        mem_q[s][wr_ptr_q[s]] <= in_entry[s];
      end
    end
  end

`ifdef REGWRITE_RR_ARB_EN
  typedef enum logic {
    PRIO_A = 1'b0,
    PRIO_B = 1'b1
  } rr_state_e;

  rr_state_e rr_q, rr_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_q <= PRIO_A;
    end else begin
      rr_q <= rr_d;
    end
  end

  always_comb begin
    rr_d    = rr_q;
    grant_a = not_empty[0] & (~not_empty[1] | (rr_q == PRIO_A));
    grant_b = not_empty[1] & ~grant_a;
    if (grant_a) begin
      rr_d = PRIO_B;
    end else if (grant_b) begin
      rr_d = PRIO_A;
    end
  end
`else
  always_comb begin
    grant_a = not_empty[0];
    grant_b = not_empty[1] & ~not_empty[0];
  end
`endif

  // Register 0 still takes a grant slot but never raises the write enable.
  always_comb begin
    win_entry = grant_a ? head[0] : head[1];
    we_d      = 1'b0;
    waddr_d   = waddr_q;
    data_d    = data_q;
    if (grant_a | grant_b) begin
      waddr_d = win_entry[ENTRY_W-1:DATA_W];
      data_d  = win_entry[DATA_W-1:0];
      we_d    = (win_entry[ENTRY_W-1:DATA_W] != '0);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_q    <= 1'b0;
      waddr_q <= '0;
      data_q  <= '0;
    end else begin
      we_q    <= we_d;
      waddr_q <= waddr_d;
      data_q  <= data_d;
    end
  end

  // Slot e of a queue is live if it is the head with count>=1, or the tail with count==2.
  always_comb begin
    pend = '0;
    for (int s = 0; s < 2; s++) begin
      for (int e = 0; e < 2; e++) begin
        if ((1'(e) == rd_ptr_q[s]) ? (cnt_q[s] != 2'd0) : (cnt_q[s] == 2'd2)) begin
          pend[mem_q[s][e][ENTRY_W-1:DATA_W]] = 1'b1;
        end
      end
    end
    if (we_q) begin
      pend[waddr_q] = 1'b1;
    end
    pend[0] = 1'b0;
  end

  assign wb.a_ready  = ready[0];
  assign wb.b_ready  = ready[1];
  assign wb.regWrite = we_q;
  assign wb.regWaddr = waddr_q;
  assign wb.data     = data_q;
  assign wb.pending  = pend;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Randomized bench for regfile_write_arbiter against a queue-based reference model.
// Build with or without REGWRITE_RR_ARB_EN; the model follows the same define.
module tb_regfile_write_arbiter;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NR = 2**AW;
`ifdef REGWRITE_RR_ARB_EN
  localparam bit RR_EN = 1'b1;
`else
  localparam bit RR_EN = 1'b0;
`endif

  typedef logic [AW+DW-1:0] ent_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  regfile_write_arbiter_if #(.DATA_W(DW), .ADDR_W(AW)) wb ();

  regfile_write_arbiter #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .wb    (wb.slave)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference state: queue contents per source, last-granted flag and output register.
  ent_t          mq_a[$];
  ent_t          mq_b[$];
  ent_t          src_a[$];
  ent_t          src_b[$];
  bit            m_last_a = 1'b0;
  bit            m_we     = 1'b0;
  logic [AW-1:0] m_waddr  = '0;
  logic [DW-1:0] m_data   = '0;
  bit            rand_valid = 1'b0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [NR-1:0] exp_pending();
    logic [NR-1:0] p = '0;
    foreach (mq_a[i]) p[mq_a[i][AW+DW-1:DW]] = 1'b1;
    foreach (mq_b[i]) p[mq_b[i][AW+DW-1:DW]] = 1'b1;
    if (m_we) p[m_waddr] = 1'b1;
    p[0] = 1'b0;
    return p;
  endfunction

  task automatic check_all(input string tag);
    check_val({tag, "/regWrite"}, 64'(wb.regWrite), 64'(m_we));
    check_val({tag, "/regWaddr"}, 64'(wb.regWaddr), 64'(m_waddr));
    check_val({tag, "/data"},     64'(wb.data),     64'(m_data));
    check_val({tag, "/a_ready"},  64'(wb.a_ready),  64'(mq_a.size() < 2));
    check_val({tag, "/b_ready"},  64'(wb.b_ready),  64'(mq_b.size() < 2));
    check_val({tag, "/pending"},  64'(wb.pending),  64'(exp_pending()));
  endtask

  task automatic drive();
    ent_t e;
    wb.a_valid = (src_a.size() > 0) && (!rand_valid || $urandom_range(0, 3) != 0);
    if (src_a.size() > 0) e = src_a[0];
    else                  e = {AW'($urandom), DW'($urandom)};
    wb.a_addr = e[AW+DW-1:DW];
    wb.a_data = e[DW-1:0];
    wb.b_valid = (src_b.size() > 0) && (!rand_valid || $urandom_range(0, 3) != 0);
    if (src_b.size() > 0) e = src_b[0];
    else                  e = {AW'($urandom), DW'($urandom)};
    wb.b_addr = e[AW+DW-1:DW];
    wb.b_data = e[DW-1:0];
  endtask

  // One clock edge of the intended behaviour, evaluated on pre-edge queue sizes.
  task automatic model_edge();
    int   sa    = mq_a.size();
    int   sb    = mq_b.size();
    bit   acc_a = wb.a_valid && sa < 2;
    bit   acc_b = wb.b_valid && sb < 2;
    bit   pick_a;
    ent_t w;
    if (sa > 0 && sb > 0) pick_a = RR_EN ? !m_last_a : 1'b1;
    else                  pick_a = (sa > 0);
    if (sa > 0 || sb > 0) begin
      if (pick_a) w = mq_a.pop_front();
      else        w = mq_b.pop_front();
      m_last_a = pick_a;
      m_waddr  = w[AW+DW-1:DW];
      m_data   = w[DW-1:0];
      m_we     = (m_waddr != 0);
    end else begin
      m_we = 1'b0;
    end
    if (acc_a) begin
      mq_a.push_back({wb.a_addr, wb.a_data});
      void'(src_a.pop_front());
    end
    if (acc_b) begin
      mq_b.push_back({wb.b_addr, wb.b_data});
      void'(src_b.pop_front());
    end
  endtask

  // Entered and left on a negedge: drive, take the posedge, then compare.
  task automatic step(input string tag);
    drive();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_all(tag);
  endtask

  initial begin
    wb.a_valid = 1'b0; wb.a_addr = '0; wb.a_data = '0;
    wb.b_valid = 1'b0; wb.b_addr = '0; wb.b_data = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_all("reset");
    rst_n = 1'b1;

    src_a.push_back({5'd8, 32'd10});
    repeat (5) step("single");

    src_b.push_back({5'd0, 32'hFFFF_FFFF});
    repeat (4) step("reg0");

    for (int i = 0; i < 3; i++) begin
      src_a.push_back({AW'(i + 1), DW'(32'hA0 + i)});
      src_b.push_back({AW'(i + 4), DW'(32'hB0 + i)});
    end
    repeat (10) step("contend");

    src_a.push_back({5'd12, 32'h1}); src_a.push_back({5'd12, 32'h2});
    src_a.push_back({5'd12, 32'h3}); src_a.push_back({5'd12, 32'h4});
    repeat (9) step("fullq");

    src_a.push_back({5'd9, 32'h9});  src_a.push_back({5'd10, 32'hA});
    src_b.push_back({5'd11, 32'hB}); src_b.push_back({5'd17, 32'h11});
    repeat (2) step("fill");
    drive();
    @(posedge clk);
    model_edge();
    #2 rst_n = 1'b0;
    #1;
    check_val("async_rst/regWrite", 64'(wb.regWrite), 64'd0);
    check_val("async_rst/regWaddr", 64'(wb.regWaddr), 64'd0);
    check_val("async_rst/data",     64'(wb.data),     64'd0);
    check_val("async_rst/pending",  64'(wb.pending),  64'd0);
    check_val("async_rst/a_ready",  64'(wb.a_ready),  64'd1);
    check_val("async_rst/b_ready",  64'(wb.b_ready),  64'd1);
    mq_a.delete(); mq_b.delete(); src_a.delete(); src_b.delete();
    m_we = 1'b0; m_waddr = '0; m_data = '0; m_last_a = 1'b0;
    drive();
    @(negedge clk);
    check_all("in_reset");
    rst_n = 1'b1;
    repeat (5) step("post_reset");

    rand_valid = 1'b1;
    repeat (500) begin
      if (src_a.size() < 3 && $urandom_range(0, 1) == 1)
        src_a.push_back({AW'($urandom_range(0, 7)), DW'($urandom)});
      if (src_b.size() < 3 && $urandom_range(0, 1) == 1)
        src_b.push_back({AW'($urandom_range(0, 7)), DW'($urandom)});
      step("random");
    end
    rand_valid = 1'b0;
    repeat (12) step("drain");

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/regfile_write_arbiter.md
# regfile_write_arbiter

Shares the single write port of the 32×32 register file between two writeback sources: A (ALU/R-type result) and B (load/memory result). Each source has a 2-entry queue with a valid/ready handshake. A round-robin arbiter drains one write per cycle onto the `regWrite`/`regWaddr`/`data` write port. The block also exports a pending-write bitmask for the hazard unit. It sits between the writeback stage and the register file, whose write port samples on the negative clock edge.

## Interface
Parameters:
- `DATA_W`, 32: write data width.
- `ADDR_W`, 5: register address width; the register count is 2^ADDR_W.

Ports:
- `clk`  in  1: clock. All state updates on the posedge.
- `rst_n`  in  1: reset. **Asynchronous, active-low.**
- `a_valid`  in  1: source A offers a write.
- `a_ready`  out  1: source A queue can accept a write.
- `a_addr`  in  ADDR_W: source A destination register.
- `a_data`  in  DATA_W: source A write data.
- `b_valid`, `b_ready`, `b_addr`, `b_data`: the same four signals for source B.
- `regWrite`  out  1: write enable to the register file.
- `regWaddr`  out  ADDR_W: write address to the register file.
- `data`  out  DATA_W: write data to the register file.
- `pending`  out  2^ADDR_W: bit i = 1 while any write to register i is queued or on the write port.

## Operation
- **Queues.** Each source has a 2-entry FIFO with a registered count (0..2).
  - `x_ready` = (count != 2). It is driven from registered state only; there is no bypass from a same-cycle pop.
  - A write is accepted on a posedge with `x_valid & x_ready`.
  - Simultaneous push and pop on a queue holding 1 entry leaves count = 1.
  - Order within one source is FIFO.
- **Arbitration.** Each posedge, the arbiter chooses among the non-empty queue heads.
  - Only one head non-empty: that source wins.
  - Both non-empty: the source not granted last wins.
  - The winner's head is popped, and its addr/data are loaded into the output register.
  - The round-robin pointer updates only on a grant.
- **Output register.**
  - On a grant: `regWrite` = (addr != 0), `regWaddr` = addr, `data` = head data.
  - No grant: `regWrite` = 0; `regWaddr` and `data` hold their previous values.
- **Register 0.** A write to register 0 still consumes a grant slot and pops its queue entry, but never asserts `regWrite`.
- **Ordering across sources.** Writes to the same register from A and B commit in grant order. Upstream must not rely on any cross-source order.
- **`pending`.** Combinational OR of:
  - decoded addresses of valid entries in both FIFOs;
  - `regWaddr` when `regWrite` = 1.

  Bit 0 is forced to 0.
- **Reset** (asserted at any time, including mid-operation):
  - both queues are emptied and queued writes are discarded;
  - `regWrite` = 0, `regWaddr` = 0, `data` = 0, `pending` = 0;
  - `a_ready` = `b_ready` = 1;
  - round-robin pointer favours A.

## Timing
- Latency: a write accepted at posedge N is loaded at posedge N+1 at the earliest. `regWrite` is high from N+1 to N+2, and the register file captures the write at the negedge inside that cycle.
- Throughput: one register-file write per cycle in total. With both sources saturated, each source gets one write every 2 cycles.
- Worst-case wait from acceptance to grant: 4 cycles (own queue depth × 2 under contention).
- A queue accepts again in the cycle after its count drops below 2 (ready is registered-state based).
- `pending` bits rise in the cycle after acceptance. A bit clears in the cycle after `regWrite` for that address deasserts, unless another queued write targets the same address.

## Configuration
- `REGWRITE_RR_ARB_EN`
  - Defined: round-robin arbitration as described above.
  - Undefined: fixed priority, A always wins when both heads are valid; the round-robin pointer is removed. B may starve under continuous A traffic. All other behaviour is identical.

## Test plan
- Single write: after reset, A writes addr 8, data 10 at edge N → `regWrite` = 1, `regWaddr` = 8, `data` = 10 during cycle N+1; `pending[8]` = 1 from N to N+2, then 0.
- Contention (`REGWRITE_RR_ARB_EN` defined): A and B each push 3 writes back-to-back with B holding `valid` high → grant order A,B,A,B,A,B. `x_ready` drops to 0 while count = 2. No write is lost or duplicated.
- Contention (macro undefined): same stimulus → all 3 A writes commit before any B write.
- Register 0: B writes addr 0, data 0xFFFFFFFF → the queue pops, `regWrite` stays 0, and `pending[0]` stays 0 throughout.
- Mid-operation reset: fill both queues (A addrs 9,10; B addrs 11,17), then assert `rst_n` = 0 asynchronously mid-cycle → outputs zero immediately, `pending` = 0, both readys = 1. After release, none of the 4 discarded writes appears on the port.
- Full queue push/pop: A queue at count 2, `a_valid` held high → exactly one accept, in the cycle after the first pop. Final `data` sequence matches push order.
